// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stim_pkg
//  Description : Shared types and default sizes for the stimulus sequencer:
//                FSM state encoding, table entry layout, default DEPTH/DLY_W.
//  Revision    : 1.0 - initial release
// ============================================================================
package stim_pkg;

   localparam int C_DEPTH = 16;
   localparam int C_DLY_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Table entry as stored and as written on the wr_data port: delay in the MSBs
   typedef struct packed {
      logic [C_DLY_W-1:0] delay;
      logic               a;
      logic               b;
   } entry_t;

endpackage
`default_nettype wire

// File: rtl/stim_delay_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stim_delay_counter
//  Description : Loadable down-counter with zero flag. It holds at zero, so a
//                full-scale load counts all the way down without wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_delay_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // Load has priority over decrement; decrement saturates at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stim_sequencer
//  Description : Table-driven stimulus sequencer. Each table entry carries a
//                delay and an (a, b) pair; entries are played in order, each
//                applied to astim/bstim after its delay, optionally looping.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_sequencer
   import stim_pkg::*;
#(
   parameter  int DEPTH = C_DEPTH,
   parameter  int DLY_W = C_DLY_W,
   localparam int AW    = $clog2(DEPTH),
   localparam int LEN_W = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [DLY_W+1:0] i_wr_data,
   input  logic [LEN_W-1:0] i_num_entries,
   input  logic             i_loop_en,
   input  logic             i_start,
   input  logic             i_abort,
   output logic             o_astim,
   output logic             o_bstim,
   output logic             o_busy,
   output logic             o_done,
   output logic [AW-1:0]    o_idx
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DLY_W+1:0] r_table [DEPTH];
   logic [AW-1:0]    r_idx;
   logic [AW-1:0]    w_idx_nxt;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] w_len_in;
   logic             r_loop;
   logic             r_pend_a;
   logic             r_pend_b;
   logic             r_astim;
   logic             r_bstim;
   logic             r_done;
   logic             w_latch;
   logic             w_fetch;
   logic             w_upd;
   logic             w_dec;
   logic             w_done_nxt;
   logic             w_zero;
   logic             w_last;
   logic [DLY_W+1:0] w_entry;

   // Requested lengths beyond the table size play the whole table once
   assign w_len_in = (i_num_entries > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_num_entries;
   assign w_last   = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
   assign w_entry  = r_table[r_idx];

   // Table write is only accepted while idle so a running sequence is never disturbed
   always_ff @(posedge i_clk) begin
      if (i_wr_en && (r_state == ST_IDLE)) begin
         r_table[i_wr_addr] <= i_wr_data;
      end
   end

   stim_delay_counter #(
      .W          (DLY_W)
   ) u_delay_counter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_fetch),
      .i_load_val (w_entry[DLY_W+1:2]),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath control; abort overrides every other transition
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_latch     = 1'b0;
      w_fetch     = 1'b0;
      w_upd       = 1'b0;
      w_dec       = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_num_entries != '0) begin
                  w_latch     = 1'b1;
                  w_idx_nxt   = '0;
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_done_nxt  = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            if (i_abort) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_fetch     = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_zero) begin
               w_dec = 1'b1;
            end else begin
               w_upd = 1'b1;
               if (w_last) begin
                  if (r_loop) begin
                     w_idx_nxt   = '0;
                     w_state_nxt = ST_FETCH;
                  end else begin
                     w_state_nxt = ST_DONE;
                  end
               end else begin
                  w_idx_nxt   = r_idx + AW'(1);
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = !i_abort;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Run parameters, pending stimulus, registered outputs and done pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx    <= '0;
         r_len    <= '0;
         r_loop   <= 1'b0;
         r_pend_a <= 1'b0;
         r_pend_b <= 1'b0;
         r_astim  <= 1'b0;
         r_bstim  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_idx  <= w_idx_nxt;
         r_done <= w_done_nxt;
         if (w_latch) begin
            r_len  <= w_len_in;
            r_loop <= i_loop_en;
         end
         if (w_fetch) begin
            r_pend_a <= w_entry[1];
            r_pend_b <= w_entry[0];
         end
         if (w_upd) begin
            r_astim <= r_pend_a;
            r_bstim <= r_pend_b;
         end
      end
   end

   assign o_astim = r_astim;
   assign o_bstim = r_bstim;
   assign o_busy  = (r_state != ST_IDLE);
   assign o_done  = r_done;
   assign o_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stim_sequencer
//  Description : Directed self-checking bench for stim_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_sequencer;
   import stim_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [9:0] wr_data;
   logic [4:0] num_entries;
   logic       loop_en;
   logic       start;
   logic       abort;
   logic       astim;
   logic       bstim;
   logic       busy;
   logic       done;
   logic [3:0] idx;

   int total = 0;
   int bad   = 0;

   stim_sequencer #(
      .DEPTH (16),
      .DLY_W (8)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wr_en       (wr_en),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .i_num_entries (num_entries),
      .i_loop_en     (loop_en),
      .i_start       (start),
      .i_abort       (abort),
      .o_astim       (astim),
      .o_bstim       (bstim),
      .o_busy        (busy),
      .o_done        (done),
      .o_idx         (idx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int addr, input int dly, input bit a, input bit b);
      entry_t e;
      e.delay = dly[7:0];
      e.a     = a;
      e.b     = b;
      wr_en   = 1'b1;
      wr_addr = addr[3:0];
      wr_data = e;
      step();
      wr_en   = 1'b0;
   endtask

   // Leaves the bench just after edge E0 (the edge that samples start)
   task automatic start_run(input int n, input bit lp);
      num_entries = n[4:0];
      loop_en     = lp;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   initial begin
      logic [1:0] exp_ab;
      int         kk;
      entry_t     e;

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      num_entries = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
      step(); step();
      check("reset_ab",   {30'd0, astim, bstim}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_idx",  {28'd0, idx}, 32'd0);
      rst_n = 1'b1;
      step();

      // basic run: {3,1,0},{0,0,1},{5,1,1}
      write_entry(0, 3, 1'b1, 1'b0);
      write_entry(1, 0, 1'b0, 1'b1);
      write_entry(2, 5, 1'b1, 1'b1);
      start_run(3, 1'b0);
      check("basic_busy_E0", {31'd0, busy}, 32'd1);
      for (int n = 1; n <= 16; n++) begin
         step();
         exp_ab = (n < 5) ? 2'b00 : (n < 7) ? 2'b10 : (n < 14) ? 2'b01 : 2'b11;
         check($sformatf("basic_ab_E%0d", n),   {30'd0, astim, bstim}, {30'd0, exp_ab});
         check($sformatf("basic_done_E%0d", n), {31'd0, done}, {31'd0, (n == 15)});
         check($sformatf("basic_busy_E%0d", n), {31'd0, busy}, {31'd0, (n <= 14)});
         if (n == 5) check("basic_idx_E5", {28'd0, idx}, 32'd1);
         if (n == 7) check("basic_idx_E7", {28'd0, idx}, 32'd2);
      end

      // zero length
      start_run(0, 1'b0);
      check("zero_done_E0", {31'd0, done}, 32'd1);
      check("zero_busy_E0", {31'd0, busy}, 32'd0);
      check("zero_ab_E0",   {30'd0, astim, bstim}, 32'd3);
      step();
      check("zero_done_E1", {31'd0, done}, 32'd0);
      check("zero_busy_E1", {31'd0, busy}, 32'd0);
      check("zero_ab_E1",   {30'd0, astim, bstim}, 32'd3);

      // loop and abort: entries 0,1 = {3,1,0},{0,0,1}
      start_run(2, 1'b1);
      check("loop_idx_E0", {28'd0, idx}, 32'd0);
      for (int n = 1; n <= 12; n++) begin
         step();
         if (n == 5)  begin check("loop_ab_E5",  {30'd0, astim, bstim}, 32'd2); check("loop_idx_E5",  {28'd0, idx}, 32'd1); end
         if (n == 7)  begin check("loop_ab_E7",  {30'd0, astim, bstim}, 32'd1); check("loop_idx_E7",  {28'd0, idx}, 32'd0); end
         if (n == 11) check("loop_ab_E11", {30'd0, astim, bstim}, 32'd1);
         if (n == 12) begin check("loop_ab_E12", {30'd0, astim, bstim}, 32'd2); check("loop_idx_E12", {28'd0, idx}, 32'd1); end
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_ab",   {30'd0, astim, bstim}, 32'd2);
      step();
      check("abort_done2", {31'd0, done}, 32'd0);
      check("abort_ab2",   {30'd0, astim, bstim}, 32'd2);

      // write and start in the same idle cycle, then blocked write/start while busy
      e.delay = 8'd2; e.a = 1'b0; e.b = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = e;
      num_entries = 5'd1; loop_en = 1'b0; start = 1'b1;
      step();
      wr_en = 1'b0; start = 1'b0;
      step();
      e.delay = 8'd0; e.a = 1'b1; e.b = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = e; num_entries = 5'd3; start = 1'b1;
      step();
      wr_en = 1'b0; start = 1'b0;
      check("blk_ab_E2",   {30'd0, astim, bstim}, 32'd2);
      step();
      check("blk_busy_E3", {31'd0, busy}, 32'd1);
      step();
      check("blk_ab_E4",   {30'd0, astim, bstim}, 32'd1);
      step();
      check("blk_done_E5", {31'd0, done}, 32'd1);
      check("blk_busy_E5", {31'd0, busy}, 32'd0);
      step();
      check("blk_done_E6", {31'd0, done}, 32'd0);
      check("blk_busy_E6", {31'd0, busy}, 32'd0);
      start_run(1, 1'b0);
      step(); step();
      check("rerun_ab_E2",   {30'd0, astim, bstim}, 32'd1);
      check("rerun_done_E2", {31'd0, done}, 32'd0);
      step(); step(); step();
      check("rerun_done_E5", {31'd0, done}, 32'd1);

      // full-scale delay counts all the way
      step();
      write_entry(0, 255, 1'b1, 1'b1);
      start_run(1, 1'b0);
      for (int n = 1; n <= 255; n++) step();
      step();
      check("dmax_ab_E256",   {30'd0, astim, bstim}, 32'd1);
      check("dmax_busy_E256", {31'd0, busy}, 32'd1);
      step();
      check("dmax_ab_E257",   {30'd0, astim, bstim}, 32'd3);
      step();
      check("dmax_done_E258", {31'd0, done}, 32'd1);
      step();

      // reset mid-WAIT at count 100
      start_run(1, 1'b0);
      for (int n = 1; n <= 156; n++) step();
      check("rstw_busy", {31'd0, busy}, 32'd1);
      check("rstw_ab",   {30'd0, astim, bstim}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("rstw_async_ab",   {30'd0, astim, bstim}, 32'd0);
      check("rstw_async_busy", {31'd0, busy}, 32'd0);
      check("rstw_async_done", {31'd0, done}, 32'd0);
      check("rstw_async_idx",  {28'd0, idx}, 32'd0);
      #3 rst_n = 1'b1;
      step();
      check("rstw_after_busy", {31'd0, busy}, 32'd0);
      check("rstw_after_done", {31'd0, done}, 32'd0);
      write_entry(0, 1, 1'b1, 1'b0);
      start_run(1, 1'b0);
      step(); step();
      check("rstw_run_ab_E2", {30'd0, astim, bstim}, 32'd0);
      step();
      check("rstw_run_ab_E3", {30'd0, astim, bstim}, 32'd2);
      step();
      check("rstw_run_done_E4", {31'd0, done}, 32'd1);
      step();

      // clamp: 31 requested, 16 entries of delay 0 with alternating a/b
      for (int k = 0; k < 16; k++) write_entry(k, 0, (k % 2) == 1, (k % 2) == 0);
      start_run(31, 1'b0);
      for (int n = 1; n <= 34; n++) begin
         step();
         if (n < 2) begin
            exp_ab = 2'b10;
         end else begin
            kk = (n - 2) / 2;
            if (kk > 15) kk = 15;
            exp_ab = ((kk % 2) == 1) ? 2'b10 : 2'b01;
         end
         check($sformatf("clamp_ab_E%0d", n),   {30'd0, astim, bstim}, {30'd0, exp_ab});
         check($sformatf("clamp_done_E%0d", n), {31'd0, done}, {31'd0, (n == 33)});
         check($sformatf("clamp_busy_E%0d", n), {31'd0, busy}, {31'd0, (n <= 32)});
         if (n == 30) check("clamp_idx_E30", {28'd0, idx}, 32'd15);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
